// File: rtl/bcd_digit_entry.sv
// -----------------------------------------------------------------------------
// bcd_digit_entry
//   Consumer of the decimal-to-BCD key encoder. Synchronizes and debounces the
//   encoder's BCD code and any-key line and accepts exactly one digit per key
//   press. Accepted digits shift into a NUM_DIGITS-wide BCD entry register.
//   Codes above 9 (several keys pressed at once) are flagged. A digit accepted
//   while the register is full sets a sticky overflow flag.
//
// Ports:
//   CLK      in   1                  system clock, rising edge
//   RST      in   1                  asynchronous active-high reset
//   b_in     in   4                  BCD code from encoder (async to CLK)
//   CHK      in   1                  any-key line from encoder (async to CLK)
//   CLR      in   1                  synchronous clear of entry register/flags
//   digits   out  4*NUM_DIGITS       entry register, newest digit in [3:0]
//   count    out  clog2(NUM_DIGITS+1) number of digits stored
//   key_stb  out  1                  one-cycle pulse when a digit is stored
//   ERR      out  1                  one-cycle pulse when accepted code > 9
//   OVF      out  1                  sticky, digit accepted while full
// -----------------------------------------------------------------------------
module bcd_digit_entry #(
    parameter int NUM_DIGITS      = 4,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic [3:0]                        b_in,
    input  logic                              CHK,
    input  logic                              CLR,
    output logic [4*NUM_DIGITS-1:0]           digits,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   count,
    output logic                              key_stb,
    output logic                              ERR,
    output logic                              OVF
);

    localparam int DGW = 4 * NUM_DIGITS;
    localparam int CW  = $clog2(NUM_DIGITS + 1);
    localparam int DW  = $clog2(DEBOUNCE_CYCLES);

    localparam logic [DW-1:0] CNT_ONE    = DW'(1);
    localparam logic [DW-1:0] CNT_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(NUM_DIGITS);
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS   = 2'd1,
        HELD    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // Two-flop synchronizers for the asynchronous encoder outputs
    logic       chk_meta_q;
    logic       chk_sync_q;
    logic [3:0] b_meta_q;
    logic [3:0] b_sync_q;

    // Debounce FSM state
    state_t        state_q;
    state_t        state_d;
    logic [DW-1:0] cnt_q;
    logic [DW-1:0] cnt_d;
    logic [3:0]    cap_q;
    logic [3:0]    cap_d;
    logic          accept_s;

    // Entry register and flags
    logic [DGW-1:0] digits_q;
    logic [DGW-1:0] digits_d;
    logic [CW-1:0]  count_q;
    logic [CW-1:0]  count_d;
    logic           key_stb_q;
    logic           key_stb_d;
    logic           err_q;
    logic           err_d;
    logic           ovf_q;
    logic           ovf_d;
    logic           is_digit_s;

    // Synchronizer flops for CHK and the BCD code
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            chk_meta_q <= 1'b0;
            chk_sync_q <= 1'b0;
            b_meta_q   <= 4'd0;
            b_sync_q   <= 4'd0;
        end else begin
            chk_meta_q <= CHK;
            chk_sync_q <= chk_meta_q;
            b_meta_q   <= b_in;
            b_sync_q   <= b_meta_q;
        end
    end

    // FSM state register with debounce counter and captured code
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cap_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
        end
    end

    // FSM next-state logic; accept_s marks the PRESS->HELD transition
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cap_d    = cap_q;
        accept_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (chk_sync_q) begin
                    state_d = PRESS;
                    cnt_d   = CNT_ONE;
                    cap_d   = b_sync_q;
                end else begin
                    state_d = IDLE;
                end
            end
            PRESS: begin
                // Any drop of CHK or change of code restarts the debounce
                if (!chk_sync_q || (b_sync_q != cap_q)) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = HELD;
                    accept_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HELD: begin
                // Code changes while held are deliberately ignored
                if (!chk_sync_q) begin
                    state_d = RELEASE;
                    cnt_d   = CNT_ONE;
                end else begin
                    state_d = HELD;
                end
            end
            RELEASE: begin
                if (chk_sync_q) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic: entry register update, strobes and overflow
    always_comb begin
        is_digit_s = (cap_q <= 4'd9);
        digits_d   = digits_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        key_stb_d  = 1'b0;
        // ERR is reported even when CLR drops the same-cycle accept
        err_d      = accept_s && !is_digit_s;
        if (CLR) begin
            digits_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else if (accept_s && is_digit_s) begin
            if (count_q < COUNT_FULL) begin
                digits_d  = (digits_q << 3'd4) | DGW'(cap_q);
                count_d   = count_q + COUNT_ONE;
                key_stb_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else begin
            digits_d = digits_q;
        end
    end

    // Registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            digits_q  <= '0;
            count_q   <= '0;
            key_stb_q <= 1'b0;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            digits_q  <= digits_d;
            count_q   <= count_d;
            key_stb_q <= key_stb_d;
            err_q     <= err_d;
            ovf_q     <= ovf_d;
        end
    end

    assign digits  = digits_q;
    assign count   = count_q;
    assign key_stb = key_stb_q;
    assign ERR     = err_q;
    assign OVF     = ovf_q;

endmodule

// File: tb/tb_bcd_digit_entry.sv
// -----------------------------------------------------------------------------
// tb_bcd_digit_entry
//   Directed bench for bcd_digit_entry. Stimulus pushes the expected response
//   of every pulse (key_stb or ERR) with the edge it must appear on; a monitor
//   pops and compares whenever the DUT pulses, and flags any pulse nobody
//   expected. Register contents are also checked directly at quiet points.
// -----------------------------------------------------------------------------
module tb_bcd_digit_entry;

    localparam int ND  = 4;
    localparam int DEB = 4;

    logic        CLK;
    logic        RST;
    logic [3:0]  b_in;
    logic        CHK;
    logic        CLR;
    logic [15:0] digits;
    logic [2:0]  count;
    logic        key_stb;
    logic        ERR;
    logic        OVF;

    typedef struct {
        bit          is_err;
        logic [15:0] dig;
        logic [2:0]  cnt;
        bit          ovf;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    bcd_digit_entry #(.NUM_DIGITS(ND), .DEBOUNCE_CYCLES(DEB)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .b_in    (b_in),
        .CHK     (CHK),
        .CLR     (CLR),
        .digits  (digits),
        .count   (count),
        .key_stb (key_stb),
        .ERR     (ERR),
        .OVF     (OVF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input bit is_err, input logic [15:0] dig, input logic [2:0] cnt,
                            input bit ovf, input int at);
        exp_t e;
        e.is_err = is_err;
        e.dig    = dig;
        e.cnt    = cnt;
        e.ovf    = ovf;
        e.cyc    = at;
        sb.push_back(e);
    endtask

    // Clean press: hold CHK for 'hold' cycles, release, and wait for IDLE.
    task automatic press(input logic [3:0] code, input int hold, input bit do_exp,
                         input bit is_err, input logic [15:0] dig, input logic [2:0] cnt,
                         input bit ovf);
        @(negedge CLK);
        b_in = code;
        CHK  = 1'b1;
        if (do_exp) push_exp(is_err, dig, cnt, ovf, cyc + DEB + 2);
        repeat (hold) @(negedge CLK);
        CHK  = 1'b0;
        b_in = 4'd0;
        repeat (12) @(negedge CLK);
    endtask

    task automatic pulse_clr;
        @(negedge CLK);
        CLR = 1'b1;
        @(negedge CLK);
        CLR = 1'b0;
    endtask

    task automatic check_regs(input string tag, input logic [15:0] dig, input logic [2:0] cnt,
                              input bit ovf);
        chk({tag, "_digits"}, 32'(digits), 32'(dig));
        chk({tag, "_count"},  32'(count),  32'(cnt));
        chk({tag, "_ovf"},    32'(OVF),    32'(ovf));
    endtask

    // Monitor: compare every DUT pulse against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            cyc = cyc + 1;
            #1;
            if (key_stb === 1'b1 || ERR === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", 32'({key_stb, ERR}), 32'h0);
                end else begin
                    e = sb.pop_front();
                    chk("pulse_err",    32'(ERR),     32'(e.is_err));
                    chk("pulse_stb",    32'(key_stb), 32'(!e.is_err));
                    chk("pulse_digits", 32'(digits),  32'(e.dig));
                    chk("pulse_count",  32'(count),   32'(e.cnt));
                    chk("pulse_ovf",    32'(OVF),     32'(e.ovf));
                    chk("pulse_cycle",  32'(cyc),     32'(e.cyc));
                end
            end
        end
    end

    // Stimulus
    initial begin
        RST  = 1'b1;
        CHK  = 1'b0;
        b_in = 4'd0;
        CLR  = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        check_regs("reset", 16'h0000, 3'd0, 1'b0);
        chk("reset_stb", 32'(key_stb), 32'h0);
        chk("reset_err", 32'(ERR), 32'h0);
        repeat (2) @(negedge CLK);

        // Key 7 held 12 cycles with a bounce on release: single strobe at edge 6
        @(negedge CLK);
        b_in = 4'd7;
        CHK  = 1'b1;
        push_exp(1'b0, 16'h0007, 3'd1, 1'b0, cyc + DEB + 2);
        repeat (12) @(negedge CLK);
        CHK = 1'b0;
        @(negedge CLK);
        CHK = 1'b1;
        @(negedge CLK);
        CHK = 1'b0;
        b_in = 4'd0;
        repeat (14) @(negedge CLK);
        check_regs("key7", 16'h0007, 3'd1, 1'b0);

        // Reset mid-PRESS with the key still held: cleared, then re-accepted
        @(negedge CLK);
        b_in = 4'd2;
        CHK  = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        #1;
        check_regs("rst_mid", 16'h0000, 3'd0, 1'b0);
        @(negedge CLK);
        RST = 1'b0;
        push_exp(1'b0, 16'h0002, 3'd1, 1'b0, cyc + DEB + 2);
        repeat (8) @(negedge CLK);
        CHK  = 1'b0;
        b_in = 4'd0;
        repeat (12) @(negedge CLK);
        check_regs("rst_held", 16'h0002, 3'd1, 1'b0);

        // Fill the register, then overflow, then clear
        pulse_clr();
        check_regs("clr1", 16'h0000, 3'd0, 1'b0);
        press(4'd1, 8, 1'b1, 1'b0, 16'h0001, 3'd1, 1'b0);
        press(4'd2, 8, 1'b1, 1'b0, 16'h0012, 3'd2, 1'b0);
        press(4'd3, 8, 1'b1, 1'b0, 16'h0123, 3'd3, 1'b0);
        press(4'd4, 8, 1'b1, 1'b0, 16'h1234, 3'd4, 1'b0);
        press(4'd5, 8, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0);
        check_regs("ovf", 16'h1234, 3'd4, 1'b1);
        pulse_clr();
        check_regs("clr2", 16'h0000, 3'd0, 1'b0);

        // Short CHK pulse is rejected
        press(4'd3, 2, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0);
        // Code toggling 3<->5 every cycle never stabilises
        @(negedge CLK);
        CHK = 1'b1;
        for (int i = 0; i < 10; i++) begin
            b_in = (i % 2 == 0) ? 4'd3 : 4'd5;
            @(negedge CLK);
        end
        CHK  = 1'b0;
        b_in = 4'd0;
        repeat (12) @(negedge CLK);
        check_regs("glitch", 16'h0000, 3'd0, 1'b0);

        // Digit 8, then multi-key code 0xB gives ERR only
        press(4'd8, 8, 1'b1, 1'b0, 16'h0008, 3'd1, 1'b0);
        press(4'hB, 10, 1'b1, 1'b1, 16'h0008, 3'd1, 1'b0);
        check_regs("err", 16'h0008, 3'd1, 1'b0);

        // CLR on the accept cycle of digit 9, key held 20 cycles
        @(negedge CLK);
        b_in = 4'd9;
        CHK  = 1'b1;
        repeat (DEB + 1) @(negedge CLK);
        CLR = 1'b1;
        @(negedge CLK);
        CLR = 1'b0;
        check_regs("clr_acc", 16'h0000, 3'd0, 1'b0);
        repeat (20 - DEB - 2) @(negedge CLK);
        CHK  = 1'b0;
        b_in = 4'd0;
        repeat (12) @(negedge CLK);
        check_regs("clr_held", 16'h0000, 3'd0, 1'b0);
        press(4'd9, 8, 1'b1, 1'b0, 16'h0009, 3'd1, 1'b0);
        check_regs("after_clr", 16'h0009, 3'd1, 1'b0);

        repeat (4) @(negedge CLK);
        chk("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
